led_pattern_gen: RTL

- Multi-channel LED pattern generator. It is the parametrised successor to the single heartbeat blinker.
- A shared prescaler produces a tick strobe at TICK_HZ.
- Each of NCH channels independently runs in OFF, ON, BLINK or BURST mode, configured through a single-cycle write port.
- After reset, channel 0 blinks at 1 Hz, so the existing heartbeat behaviour is preserved. The block sits at the top level and drives the board LEDs.

---
 rtl/led_pattern_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler plus NCH independent
// OFF/ON/BLINK/BURST channels, configured through a single-cycle write port.
module led_pattern_gen #(
    parameter int CLKFREQ    = 16000000,
    parameter int TICK_HZ    = 1000,
    parameter int NCH        = 4,
    parameter int CH_W       = 2,
    parameter int BURST_ON   = 100,
    parameter int BURST_GAP  = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [1:0]      cfg_mode,
    input  logic [15:0]     cfg_arg,
    output logic            tick,
    output logic [NCH-1:0]  led
);

    localparam int PRESCALE = CLKFREQ / TICK_HZ;
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [15:0]      BLINK_RST = 16'(TICK_HZ / 2);
    localparam logic [15:0]      ON_LEN    = 16'(BURST_ON);
    localparam logic [15:0]      GAP_LEN   = 16'(BURST_GAP);

    typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BURST = 2'd3} mode_e;
    typedef enum logic [1:0] {B_ON = 2'd0, B_OFF = 2'd1, B_GAP = 2'd2} bstate_e;

    // A zero half-period would never terminate, so it is treated as one tick.
    function automatic logic [15:0] half_period(input logic [15:0] arg);
        return (arg == 16'd0) ? 16'd1 : arg;
    endfunction

    function automatic logic phase_done(input logic [15:0] cnt, input logic [15:0] len);
        return ({1'b0, cnt} + 17'd1) == {1'b0, len};
    endfunction

    logic [PRE_W-1:0] pre_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    logic [NCH-1:0] lvl_vec;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mode_e       mode_q, mode_d;
        bstate_e     bst_q, bst_d;
        logic [15:0] arg_q, arg_d;
        logic [15:0] cnt_q, cnt_d;
        logic [3:0]  bcnt_q, bcnt_d;
        logic        lvl_q, lvl_d;
        logic        wr_hit;

        // Channel indices beyond NCH-1 never match any instance, so they are ignored.
        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mode_q <= (i == 0) ? M_BLINK : M_OFF;
                arg_q  <= (i == 0) ? BLINK_RST : 16'd0;
                cnt_q  <= '0;
                bcnt_q <= '0;
                bst_q  <= B_ON;
                lvl_q  <= 1'b0;
            end else begin
                mode_q <= mode_d;
                arg_q  <= arg_d;
                cnt_q  <= cnt_d;
                bcnt_q <= bcnt_d;
                bst_q  <= bst_d;
                lvl_q  <= lvl_d;
            end
        end

        always_comb begin
            mode_d = mode_q;
            arg_d  = arg_q;
            cnt_d  = cnt_q;
            bcnt_d = bcnt_q;
            bst_d  = bst_q;
            lvl_d  = lvl_q;
            // A write on a tick cycle takes precedence; that tick is dropped for this channel.
            if (wr_hit) begin
                mode_d = mode_e'(cfg_mode);
                arg_d  = cfg_arg;
                cnt_d  = '0;
                bcnt_d = 4'd1;
                bst_d  = B_ON;
                lvl_d  = (mode_d != M_OFF) && !(mode_d == M_BURST && cfg_arg[3:0] == 4'd0);
            end else if (tick) begin
                case (mode_q)
                    M_BLINK: begin
                        if (phase_done(cnt_q, half_period(arg_q))) begin
                            cnt_d = '0;
                            lvl_d = ~lvl_q;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    M_BURST: begin
                        if (arg_q[3:0] == 4'd0) begin
                            lvl_d = 1'b0;
                        end else begin
                            case (bst_q)
                                B_ON: begin
                                    if (phase_done(cnt_q, ON_LEN)) begin
                                        cnt_d = '0;
                                        lvl_d = 1'b0;
                                        bst_d = (bcnt_q == arg_q[3:0]) ? B_GAP : B_OFF;
                                    end else begin
                                        cnt_d = cnt_q + 16'd1;
                                    end
                                end
                                B_OFF: begin
                                    if (phase_done(cnt_q, ON_LEN)) begin
                                        cnt_d  = '0;
                                        lvl_d  = 1'b1;
                                        bst_d  = B_ON;
                                        bcnt_d = bcnt_q + 4'd1;
                                    end else begin
                                        cnt_d = cnt_q + 16'd1;
                                    end
                                end
                                B_GAP: begin
                                    if (phase_done(cnt_q, GAP_LEN)) begin
                                        cnt_d  = '0;
                                        lvl_d  = 1'b1;
                                        bst_d  = B_ON;
                                        bcnt_d = 4'd1;
                                    end else begin
                                        cnt_d = cnt_q + 16'd1;
                                    end
                                end
                                default: begin
                                    cnt_d = '0;
                                    bst_d = B_ON;
                                end
                            endcase
                        end
                    end
                    default: lvl_d = (mode_q == M_ON);
                endcase
            end
        end

        assign lvl_vec[i] = lvl_q;
    end

    always_comb begin
        led = lvl_vec ^ {NCH{ACTIVE_LOW != 0}};
    end

endmodule
